// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: waveform select encoding and default widths.
package synth_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SQUARE = 2'd1,
        SAW    = 2'd2,
        TRI    = 2'd3
    } wave_t;

    localparam int unsigned ACC_W_DEF = 16;
    localparam int unsigned OUT_W_DEF = 8;

endpackage

// File: rtl/phase_accum.sv
// Phase accumulator with clear, enable and carry-out.
// Ports:
//   clk, rst      - clock, async active-high reset
//   i_en          - load acc with the next phase this cycle
//   i_clear       - next phase is 0 instead of acc + i_inc (no carry)
//   i_inc         - phase increment
//   o_tap_c       - top TAP_W bits of the next phase (combinational)
//   o_carry_c     - carry out of acc + i_inc (combinational, 0 when clearing)
module phase_accum #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned TAP_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [ACC_W-1:0] i_inc,
    output logic [TAP_W-1:0] o_tap_c,
    output logic             o_carry_c
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] r_acc;
    logic [SUM_W-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_next;

    // One extra bit on the add captures the overflow carry.
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(i_inc);
    assign w_acc_next = i_clear ? '0 : w_sum[ACC_W-1:0];
    assign o_carry_c  = ~i_clear & w_sum[ACC_W];
    assign o_tap_c    = w_acc_next[ACC_W-1 -: TAP_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: rtl/wave_shaper.sv
// Waveform generator: turns a phase accumulator into OFF/SQUARE/SAW/TRI samples,
// one registered sample per sample_en tick.
// Ports:
//   clk, rst      - clock, async active-high reset
//   mode          - waveform select (0=OFF, 1=SQUARE, 2=SAW, 3=TRI), sampled on sample_en
//   phase_inc     - frequency word, sampled on sample_en
//   sample_en     - single-cycle sample-rate tick
//   sample        - current unsigned sample, held between ticks
//   sample_valid  - one-cycle pulse after each tick
//   phase_wrap    - one-cycle pulse with sample_valid when the accumulator overflowed
module wave_shaper
    import synth_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [ACC_W-1:0] phase_inc,
    input  logic             sample_en,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic             phase_wrap
);

    localparam int unsigned TAP_W = OUT_W + 1;

    wave_t            r_mode;
    wave_t            w_mode;
    logic             w_clear;
    logic [TAP_W-1:0] w_tap;
    logic             w_carry;
    logic [OUT_W-1:0] w_tri;
    logic [OUT_W-1:0] w_shape;

    assign w_mode = wave_t'(mode);

    // OFF holds phase at 0; leaving OFF restarts at phase 0 without applying the increment.
    assign w_clear = (w_mode == OFF) || (r_mode == OFF);

    phase_accum #(
        .ACC_W (ACC_W),
        .TAP_W (TAP_W)
    ) u_phase_accum (
        .clk       (clk),
        .rst       (rst),
        .i_en      (sample_en),
        .i_clear   (w_clear),
        .i_inc     (phase_inc),
        .o_tap_c   (w_tap),
        .o_carry_c (w_carry)
    );

    // Triangle folds the second half-period by inverting the bits below the MSB.
    assign w_tri = w_tap[OUT_W-1:0];

    // Shape mux on the next phase so the sample lands on the same edge as the acc update.
    always_comb begin
        w_shape = '0;
        case (w_mode)
            OFF:     w_shape = '0;
            SQUARE:  w_shape = {OUT_W{w_tap[OUT_W]}};
            SAW:     w_shape = w_tap[OUT_W:1];
            TRI:     w_shape = w_tap[OUT_W] ? ~w_tri : w_tri;
            default: w_shape = '0;
        endcase
    end

    // Output and mode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= OFF;
            sample       <= '0;
            sample_valid <= 1'b0;
            phase_wrap   <= 1'b0;
        end else begin
            sample_valid <= sample_en;
            phase_wrap   <= sample_en & w_carry;
            if (sample_en) begin
                r_mode <= w_mode;
                sample <= w_shape;
            end
        end
    end

endmodule

// File: doc/wave_shaper.md
Name: wave_shaper

Overview:
- Downstream stage of the waveform mode selector.
- Consumes the 2-bit mode (OFF, SQUARE, SAW, TRI) and a per-note phase increment.
- Produces one unsigned audio sample per sample-rate tick from a phase accumulator.
- Output feeds the DAC/PWM stage; one sample per sample_en, registered, with a valid strobe.

Parameters:
- ACC_W, 16: phase accumulator width. Must be >= OUT_W+1.
- OUT_W, 8: sample width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- mode  in  2  waveform select: 0=OFF, 1=SQUARE, 2=SAW, 3=TRI.
- phase_inc  in  ACC_W  phase increment per sample tick (frequency word).
- sample_en  in  1  single-cycle sample-rate tick.
- sample  out  OUT_W  current sample, unsigned.
- sample_valid  out  1  one-cycle pulse; sample updated this cycle.
- phase_wrap  out  1  one-cycle pulse, coincident with sample_valid, when the accumulator overflowed on that tick.

Behaviour:
- Reset (async assert, any cycle, including mid-operation):
  - acc=0, mode_q=OFF, sample=0, sample_valid=0, phase_wrap=0.
  - First tick after deassert is processed normally.
- mode and phase_inc are sampled only on cycles with sample_en=1. Changes between ticks have no effect until the next tick.
- On sample_en=1, with mode_q the previous latched mode and m the new mode:
  - m==OFF: acc_next=0; wrap=0.
  - m!=OFF and mode_q==OFF: acc_next=0. A restart from OFF always begins at phase 0; the increment is not applied on this tick; wrap=0.
  - Otherwise: {carry, acc_next} = acc + phase_inc (ACC_W+1-bit add, modulo 2^ACC_W); wrap=carry.
  - mode_q <= m; acc <= acc_next.
- Switching between two non-OFF modes keeps the phase; only the shape changes.
- Shape is computed from acc_next and registered on the same edge:
  - OFF: 0.
  - SQUARE: acc_next[ACC_W-1] ? all-ones : 0.
  - SAW: acc_next[ACC_W-1 -: OUT_W].
  - TRI: let t = acc_next[ACC_W-2 -: OUT_W]. Sample is t when acc_next[ACC_W-1]==0, else ~t.
  - TRI peaks at all-ones and returns to 0 with no repeated endpoint glitch beyond the natural fold.
- Latency: sample, sample_valid and phase_wrap update on the clock edge where sample_en=1. They are visible the cycle after the tick is presented, i.e. 1 cycle.
- sample_valid=1 only in the cycle following each sample_en. Otherwise 0.
- sample holds its value between ticks.
- Back-to-back sample_en (every cycle) is legal: one sample per cycle.
- phase_inc=0 with mode!=OFF: acc frozen; constant output; no wrap.
- phase_inc=all-ones: acc decrements by 1 each tick (mod wrap); wrap=1 on every tick except when acc==0.

Decomposition:
- Shared package synth_pkg holds:
  - typedef enum logic [1:0] wave_t {OFF, SQUARE, SAW, TRI}. The mode selector moves to it too.
  - Default widths: ACC_W_DEF=16, OUT_W_DEF=8.
- One sub-module, phase_accum:
  - Holds the acc register, clear, enable, increment and carry-out.
  - Shape mux and output registers stay in wave_shaper.

Test Plan:
1. Reset: assert rst mid-stream with mode=SAW, acc≠0 → sample=0, sample_valid=0 immediately (async). After release, first tick with mode=OFF gives sample=0x00.
2. SAW: mode OFF→SAW, phase_inc=0x1000, 20 ticks.
   - Tick 1 (restart) gives 0x00.
   - Tick n gives (n-1)*0x10 mod 0x100.
   - 0xF0 then 0x00, with phase_wrap=1 on tick 17 only.
3. SQUARE: phase_inc=0x2000 after restart → samples 00,00,00,00,FF,FF,FF,FF repeating; phase_wrap on every 8th tick.
4. TRI: phase_inc=0x2000 → samples 00,40,80,C0,FF,BF,7F,3F,00 repeating.
5. Mode switch mid-period: SAW at acc=0x5000, switch to SQUARE with phase_inc=0x1000 → next sample=0x00 (acc=0x6000, no phase reset). Switching to OFF then back restarts at 0x00.
6. Gating: toggle mode and phase_inc with sample_en=0 for 10 cycles → sample and sample_valid unchanged. Continuous sample_en → sample_valid high every cycle.
